ps2_letter_fifo: RTL

Parametrised successor to the keyboard letter decoder. Consumes the raw PS/2 scan-code byte stream as a one-cycle strobe on CLOCK_50. Tracks the E0 (extended) and F0 (break) prefix sequences, keeps a held-key bitmap, and optionally suppresses typematic repeats. Each accepted letter event goes into a DEPTH-entry FIFO that drains over a valid/ready handshake toward the rotor/reflector path.

---
 rtl/ps2_pkg.sv | 66 ++++++
 rtl/letter_fifo.sv | 56 +++++
 rtl/ps2_letter_fifo.sv | 105 ++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps2_pkg
// Brief   : Prefix states, prefix bytes and the set-2 letter map for PS/2 decode
// Revision: 1.0 - initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_e;

  localparam logic [7:0] CODE_E0     = 8'hE0;
  localparam logic [7:0] CODE_F0     = 8'hF0;
  localparam int         NUM_LETTERS = 26;

  typedef struct packed {
    logic       hit;
    logic [4:0] index;
  } letter_hit_t;

  function automatic letter_hit_t letter_map(input logic [7:0] code);
    letter_hit_t r;
    r.hit   = 1'b1;
    r.index = 5'd0;
    case (code)
      8'h1C: r.index = 5'd0;
      8'h32: r.index = 5'd1;
      8'h21: r.index = 5'd2;
      8'h23: r.index = 5'd3;
      8'h24: r.index = 5'd4;
      8'h2B: r.index = 5'd5;
      8'h34: r.index = 5'd6;
      8'h33: r.index = 5'd7;
      8'h43: r.index = 5'd8;
      8'h3B: r.index = 5'd9;
      8'h42: r.index = 5'd10;
      8'h4B: r.index = 5'd11;
      8'h3A: r.index = 5'd12;
      8'h31: r.index = 5'd13;
      8'h44: r.index = 5'd14;
      8'h4D: r.index = 5'd15;
      8'h15: r.index = 5'd16;
      8'h2D: r.index = 5'd17;
      8'h1B: r.index = 5'd18;
      8'h2C: r.index = 5'd19;
      8'h3C: r.index = 5'd20;
      8'h2A: r.index = 5'd21;
      8'h1D: r.index = 5'd22;
      8'h22: r.index = 5'd23;
      8'h35: r.index = 5'd24;
      8'h1A: r.index = 5'd25;
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [NUM_LETTERS-1:0] letter_onehot(input logic [4:0] index);
    return 26'd1 << index;
  endfunction

endpackage
`default_nettype wire

// File: rtl/letter_fifo.sv
`default_nettype none
// ============================================================================
// Module  : letter_fifo
// Brief   : DEPTH x 5 synchronous FIFO of letter indices, no read bypass
// Revision: 1.0 - initial release
// ============================================================================
module letter_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [4:0]                 wdata,
  output logic [4:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [4:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Storage is not reset; an empty FIFO presents index 0.
  assign rdata = empty ? 5'd0 : mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/ps2_letter_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ps2_letter_fifo
// Brief   : PS/2 set-2 letter decoder with held bitmap feeding a letter FIFO
// Revision: 1.0 - initial release
// ============================================================================
module ps2_letter_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH           = 8,
  parameter bit EMIT_ON_BREAK   = 1'b0,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic [7:0]                 scan_code,
  input  logic                       scan_valid,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [4:0]                 out_index,
  output logic [25:0]                out_letter,
  output logic [25:0]                held,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  prefix_state_e state;
  prefix_state_e state_next;
  letter_hit_t   lk;
  logic          is_make;
  logic          is_break;
  logic          was_held;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;

  assign lk = letter_map(scan_code);

  always_comb begin
    state_next = state;
    is_make    = 1'b0;
    is_break   = 1'b0;
    if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          if (scan_code == CODE_E0)      state_next = ST_EXT;
          else if (scan_code == CODE_F0) state_next = ST_BRK;
          else begin
            is_make    = lk.hit;
            state_next = ST_IDLE;
          end
        end
        ST_EXT:  state_next = (scan_code == CODE_F0) ? ST_EXT_BRK : ST_IDLE;
        ST_BRK: begin
          is_break   = lk.hit;
          state_next = ST_IDLE;
        end
        ST_EXT_BRK: state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  assign was_held = held[lk.index];
  assign pop      = out_valid && out_ready;

  always_comb begin
    push = 1'b0;
    if (EMIT_ON_BREAK) push = is_break;
    else               push = is_make && !(SUPPRESS_REPEAT && was_held);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      held     <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (is_make)       held <= held | letter_onehot(lk.index);
      else if (is_break) held <= held & ~letter_onehot(lk.index);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  letter_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (CLOCK_50),
    .rst  (reset),
    .push (push),
    .pop  (pop),
    .wdata(lk.index),
    .rdata(out_index),
    .count(count),
    .full (full),
    .empty(empty)
  );

  assign out_valid  = !empty;
  assign out_letter = letter_onehot(out_index);

endmodule
`default_nettype wire
